// File: rtl/controlador_cafeteira.sv
// Capsule coffee machine controller: selection, payment, pump/heat/deliver sequencing, change return.
// Latency: every output is registered; a state change shows on sel one cycle after the triggering input.
// Backpressure: none; one-cycle pulse inputs, rejected notes are handed back with a devolve pulse.
// Optional payment inactivity timeout is enabled by defining CAFETEIRA_TIMEOUT_EN.
module controlador_cafeteira #(
    parameter int T_BOMBA   = 50,
    parameter int T_AQUEC   = 50,
    parameter int T_ENTREGA = 20,
    parameter int T_TROCO   = 20
`ifdef CAFETEIRA_TIMEOUT_EN
    ,
    parameter int T_TIMEOUT = 1000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicia,
    input  logic       confirma,
    input  logic       cancela,
    input  logic [1:0] bebida,
    input  logic       nota_valida,
    input  logic [3:0] nota_valor,
    input  logic       agua_ok,
    input  logic       capsula_ok,
    input  logic       copo_ok,
    output logic [2:0] sel,
    output logic [4:0] soma,
    output logic [2:0] sensor,
    output logic       cedulaINV,
    output logic       valoramais,
    output logic       bomba,
    output logic       aquecedor,
    output logic       entrega,
    output logic       devolve
);

    localparam logic [2:0] ST_IDLE      = 3'b000;
    localparam logic [2:0] ST_SELECAO   = 3'b001;
    localparam logic [2:0] ST_PAGAMENTO = 3'b010;
    localparam logic [2:0] ST_BOMBA     = 3'b011;
    localparam logic [2:0] ST_AQUEC     = 3'b100;
    localparam logic [2:0] ST_ENTREGA   = 3'b101;
    localparam logic [2:0] ST_ERRO      = 3'b110;
    localparam logic [2:0] ST_TROCO     = 3'b111;

    // Phase counter only needs to hold the longest timed phase.
    localparam int PH_A   = (T_BOMBA > T_AQUEC) ? T_BOMBA : T_AQUEC;
    localparam int PH_B   = (T_ENTREGA > T_TROCO) ? T_ENTREGA : T_TROCO;
    localparam int PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
    localparam int CW     = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    credit_q, credit_d;
    logic [3:0]    troco_q, troco_d;
    logic [1:0]    bebida_q, bebida_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    soma_q, soma_d;
    logic [2:0]    sensor_q, sensor_d;
    logic          cedula_inv_q, cedula_inv_d;
    logic          valoramais_q, valoramais_d;
    logic          bomba_q, bomba_d;
    logic          aquecedor_q, aquecedor_d;
    logic          entrega_q, entrega_d;
    logic          devolve_q, devolve_d;
    logic          reject;

    logic [3:0]    price;
    logic [2:0]    missing;
    logic [4:0]    sum_next;
    logic          nota_ok;
    logic [CW-1:0] last_cnt;
    logic          timed;
    logic          phase_done;

`ifdef CAFETEIRA_TIMEOUT_EN
    localparam int TW = $clog2(T_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    assign tmo_hit = (tmo_q == TW'(T_TIMEOUT));
`endif

    assign missing  = ~{copo_ok, capsula_ok, agua_ok};
    assign sum_next = {1'b0, credit_q} + {1'b0, nota_valor};
    assign nota_ok  = (nota_valor == 4'd2) || (nota_valor == 4'd5);

    // Fixed price table indexed by the latched drink.
    always_comb begin
        price = 4'd4;
        case (bebida_q)
            2'b00:   price = 4'd4;
            2'b01:   price = 4'd6;
            2'b10:   price = 4'd5;
            default: price = 4'd8;
        endcase
    end

    // Last counter value of the current timed phase; a phase of length T ends at count T-1.
    always_comb begin
        last_cnt = '0;
        timed    = 1'b1;
        case (state_q)
            ST_BOMBA:   last_cnt = CW'(T_BOMBA - 1);
            ST_AQUEC:   last_cnt = CW'(T_AQUEC - 1);
            ST_ENTREGA: last_cnt = CW'(T_ENTREGA - 1);
            ST_TROCO:   last_cnt = CW'(T_TROCO - 1);
            default:    timed    = 1'b0;
        endcase
    end

    assign phase_done = timed && (cnt_q == last_cnt);

    // Next-state, credit and sensor logic.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        troco_d      = troco_q;
        bebida_d     = bebida_q;
        sensor_d     = sensor_q;
        valoramais_d = valoramais_q;
        cedula_inv_d = 1'b0;
        reject       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inicia) state_d = ST_SELECAO;
            end
            ST_SELECAO: begin
                if (cancela) begin
                    state_d = ST_IDLE;
                end else if (confirma) begin
                    bebida_d = bebida;
                    if (missing != 3'b000) begin
                        state_d  = ST_ERRO;
                        sensor_d = missing;
                    end else begin
                        state_d      = ST_PAGAMENTO;
                        credit_d     = 4'd0;
                        valoramais_d = 1'b0;
                    end
                end
            end
            ST_ERRO: begin
                sensor_d = missing;
                if (cancela) begin
                    state_d  = ST_IDLE;
                    sensor_d = 3'b000;
                end else if (confirma && (missing == 3'b000)) begin
                    state_d = ST_SELECAO;
                end
            end
            ST_PAGAMENTO: begin
                // Payment already complete takes precedence; any note arriving now is handed back.
                if (credit_q >= price) begin
                    state_d      = ST_BOMBA;
                    troco_d      = credit_q - price;
                    valoramais_d = 1'b0;
                    reject       = nota_valida;
                end else if (cancela) begin
                    valoramais_d = 1'b0;
                    reject       = nota_valida;
                    if (credit_q != 4'd0) begin
                        state_d = ST_TROCO;
                        troco_d = credit_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (nota_valida) begin
                    if (!nota_ok) begin
                        cedula_inv_d = 1'b1;
                        reject       = 1'b1;
                    end else if (sum_next > 5'd10) begin
                        reject       = 1'b1;
                        valoramais_d = 1'b1;
                    end else begin
                        credit_d     = sum_next[3:0];
                        valoramais_d = 1'b0;
                    end
`ifdef CAFETEIRA_TIMEOUT_EN
                end else if (tmo_hit) begin
                    valoramais_d = 1'b0;
                    if (credit_q != 4'd0) begin
                        state_d = ST_TROCO;
                        troco_d = credit_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            ST_BOMBA: begin
                if (phase_done) state_d = ST_AQUEC;
            end
            ST_AQUEC: begin
                if (phase_done) state_d = ST_ENTREGA;
            end
            ST_ENTREGA: begin
                if (phase_done) state_d = (troco_q != 4'd0) ? ST_TROCO : ST_IDLE;
            end
            default: begin
                if (phase_done) state_d = ST_IDLE;
            end
        endcase
        // Returning to IDLE always leaves a clean slate for the next customer.
        if (state_d == ST_IDLE) begin
            credit_d = 4'd0;
            troco_d  = 4'd0;
        end
    end

    // Phase counter restarts on every state change.
    always_comb begin
        cnt_d = '0;
        if (timed && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
    end

`ifdef CAFETEIRA_TIMEOUT_EN
    // Inactivity counter runs only while staying in payment with no note offered.
    always_comb begin
        tmo_d = '0;
        if ((state_q == ST_PAGAMENTO) && (state_d == ST_PAGAMENTO) && !nota_valida)
            tmo_d = tmo_q + 1'b1;
    end
`endif

    // Output values computed from the next state so they line up with sel.
    always_comb begin
        soma_d      = (state_d == ST_TROCO) ? {1'b0, troco_d} : {1'b0, credit_d};
        devolve_d   = reject || (state_d == ST_TROCO);
        bomba_d     = (state_d == ST_BOMBA);
        aquecedor_d = (state_d == ST_AQUEC);
        entrega_d   = (state_d == ST_ENTREGA);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            credit_q     <= 4'd0;
            troco_q      <= 4'd0;
            bebida_q     <= 2'b00;
            cnt_q        <= '0;
            soma_q       <= 5'd0;
            sensor_q     <= 3'b000;
            cedula_inv_q <= 1'b0;
            valoramais_q <= 1'b0;
            bomba_q      <= 1'b0;
            aquecedor_q  <= 1'b0;
            entrega_q    <= 1'b0;
            devolve_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            troco_q      <= troco_d;
            bebida_q     <= bebida_d;
            cnt_q        <= cnt_d;
            soma_q       <= soma_d;
            sensor_q     <= sensor_d;
            cedula_inv_q <= cedula_inv_d;
            valoramais_q <= valoramais_d;
            bomba_q      <= bomba_d;
            aquecedor_q  <= aquecedor_d;
            entrega_q    <= entrega_d;
            devolve_q    <= devolve_d;
        end
    end

`ifdef CAFETEIRA_TIMEOUT_EN
    // Inactivity counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    assign sel        = state_q;
    assign soma       = soma_q;
    assign sensor     = sensor_q;
    assign cedulaINV  = cedula_inv_q;
    assign valoramais = valoramais_q;
    assign bomba      = bomba_q;
    assign aquecedor  = aquecedor_q;
    assign entrega    = entrega_q;
    assign devolve    = devolve_q;

endmodule

// File: tb/tb_controlador_cafeteira.sv
// Bench for controlador_cafeteira: directed scenarios with literal checks,
// plus a phase-level model compared against every output on every falling edge.
// Covers the CAFETEIRA_TIMEOUT_EN build too when that macro is defined.
module tb_controlador_cafeteira;

    localparam int T_B   = 50;
    localparam int T_A   = 50;
    localparam int T_E   = 20;
    localparam int T_T   = 20;
    localparam int T_TMO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       inicia = 1'b0, confirma = 1'b0, cancela = 1'b0;
    logic [1:0] bebida = 2'b00;
    logic       nota_valida = 1'b0;
    logic [3:0] nota_valor = 4'd0;
    logic       agua_ok = 1'b1, capsula_ok = 1'b1, copo_ok = 1'b1;
    logic [2:0] sel;
    logic [4:0] soma;
    logic [2:0] sensor;
    logic       cedulaINV, valoramais, bomba, aquecedor, entrega, devolve;

    int total = 0;
    int bad   = 0;
    bit dev_seen = 1'b0;

    controlador_cafeteira #(
        .T_BOMBA(T_B), .T_AQUEC(T_A), .T_ENTREGA(T_E), .T_TROCO(T_T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inicia(inicia), .confirma(confirma), .cancela(cancela),
        .bebida(bebida), .nota_valida(nota_valida), .nota_valor(nota_valor),
        .agua_ok(agua_ok), .capsula_ok(capsula_ok), .copo_ok(copo_ok),
        .sel(sel), .soma(soma), .sensor(sensor), .cedulaINV(cedulaINV),
        .valoramais(valoramais), .bomba(bomba), .aquecedor(aquecedor),
        .entrega(entrega), .devolve(devolve)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: phase + cycles remaining ----------------
    int m_phase, m_left, m_credit, m_troco, m_drink, m_idle;
    bit m_inv, m_over, m_dev;
    logic [2:0] m_sensor;
    int prices [4] = '{4, 6, 5, 8};

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_credit = 0; m_troco = 0; m_drink = 0; m_idle = 0;
        m_inv = 0; m_over = 0; m_dev = 0; m_sensor = 3'b000;
    endtask

    task automatic enter_change_or_idle(input int amount);
        if (amount > 0) begin m_troco = amount; m_phase = 7; m_left = T_T; end
        else begin m_phase = 0; m_credit = 0; end
    endtask

    task automatic model_step();
        logic [2:0] miss;
        int v;
        miss = {~copo_ok, ~capsula_ok, ~agua_ok};
        v = int'(nota_valor);
        m_inv = 0; m_dev = 0;
        case (m_phase)
            0: if (inicia) m_phase = 1;
            1: if (cancela) m_phase = 0;
               else if (confirma) begin
                   m_drink = int'(bebida);
                   if (miss != 0) begin m_sensor = miss; m_phase = 6; end
                   else begin m_phase = 2; m_credit = 0; m_over = 0; m_idle = 0; end
               end
            6: if (cancela) begin m_phase = 0; m_sensor = 0; end
               else begin
                   m_sensor = miss;
                   if (confirma && miss == 0) m_phase = 1;
               end
            2: if (m_credit >= prices[m_drink]) begin
                   m_troco = m_credit - prices[m_drink];
                   m_phase = 3; m_left = T_B; m_over = 0; m_dev = nota_valida;
               end else if (cancela) begin
                   m_over = 0; m_dev = nota_valida;
                   enter_change_or_idle(m_credit);
               end else if (nota_valida) begin
                   m_idle = 0;
                   if (v != 2 && v != 5) begin m_inv = 1; m_dev = 1; end
                   else if (m_credit + v > 10) begin m_dev = 1; m_over = 1; end
                   else begin m_credit = m_credit + v; m_over = 0; end
               end else begin
`ifdef CAFETEIRA_TIMEOUT_EN
                   if (m_idle == T_TMO) begin
                       m_over = 0;
                       enter_change_or_idle(m_credit);
                   end else m_idle++;
`endif
               end
            3: begin m_left--; if (m_left == 0) begin m_phase = 4; m_left = T_A; end end
            4: begin m_left--; if (m_left == 0) begin m_phase = 5; m_left = T_E; end end
            5: begin m_left--; if (m_left == 0) enter_change_or_idle(m_troco); end
            default: begin m_left--; if (m_left == 0) begin m_phase = 0; m_credit = 0; m_troco = 0; end end
        endcase
        if (m_phase == 0) m_credit = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    function automatic logic [16:0] model_vec();
        logic [4:0] s;
        s = (m_phase == 7) ? 5'(m_troco) : 5'(m_credit);
        return {3'(m_phase), s, m_sensor, m_inv, m_over,
                (m_phase == 3), (m_phase == 4), (m_phase == 5), (m_dev || m_phase == 7)};
    endfunction

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        logic [16:0] act, expv;
        act  = {sel, soma, sensor, cedulaINV, valoramais, bomba, aquecedor, entrega, devolve};
        expv = model_vec();
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL model_cmp t=%0t: dut=%b model=%b", $time, act, expv);
        end
        if (devolve === 1'b1) dev_seen = 1'b1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic step(input logic i, input logic c, input logic k, input logic nv, input logic [3:0] v);
        inicia = i; confirma = c; cancela = k; nota_valida = nv; nota_valor = v;
        @(negedge clk);
        inicia = 0; confirma = 0; cancela = 0; nota_valida = 0; nota_valor = 0;
    endtask

    task automatic note(input logic [3:0] v);
        step(0, 0, 0, 1, v);
    endtask

    task automatic wait_sel(input logic [2:0] s, input int budget);
        int n = 0;
        while (sel !== s && n < budget) begin @(negedge clk); n++; end
        chk($sformatf("reach_sel_%0d", s), int'(sel), int'(s));
    endtask

    task automatic count_sel(input logic [2:0] s, output int n);
        n = 0;
        while (sel === s && n < 2000) begin n++; @(negedge clk); end
    endtask

    task automatic start_drink(input logic [1:0] b);
        bebida = b;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sel", int'(sel), 0);
        chk("rst_soma", int'(soma), 0);
        chk("rst_flags", int'({sensor, cedulaINV, valoramais, bomba, aquecedor, entrega, devolve}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Expresso paid exactly with 2+2.
        dev_seen = 0;
        bebida = 2'b00;
        step(1, 0, 0, 0, 0);
        chk("s1_selecao", int'(sel), 1);
        step(0, 1, 0, 0, 0);
        chk("s1_pagamento", int'(sel), 2);
        note(4'd2);
        chk("s1_soma2", int'(soma), 2);
        note(4'd2);
        chk("s1_soma4", int'(soma), 4);
        chk("s1_still_pag", int'(sel), 2);
        @(negedge clk);
        chk("s1_bomba", int'(sel), 3);
        chk("s1_bomba_on", int'(bomba), 1);
        count_sel(3'b011, n); chk("s1_len_bomba", n, 50);
        count_sel(3'b100, n); chk("s1_len_aquec", n, 50);
        count_sel(3'b101, n); chk("s1_len_entrega", n, 20);
        chk("s1_idle", int'(sel), 0);
        chk("s1_no_devolve", int'(dev_seen), 0);

        // Com leite, 5+2, change of 1.
        start_drink(2'b01);
        note(4'd5);
        note(4'd2);
        chk("s2_soma7", int'(soma), 7);
        @(negedge clk);
        chk("s2_bomba", int'(sel), 3);
        wait_sel(3'b111, 200);
        chk("s2_troco", int'(soma), 1);
        chk("s2_devolve", int'(devolve), 1);
        count_sel(3'b111, n); chk("s2_len_troco", n, 20);
        chk("s2_idle", int'(sel), 0);

        // Cappuccino: invalid note, over-limit, then cancel with a note in flight.
        start_drink(2'b11);
        note(4'd3);
        chk("s3_inv", int'(cedulaINV), 1);
        chk("s3_inv_dev", int'(devolve), 1);
        chk("s3_inv_soma", int'(soma), 0);
        @(negedge clk);
        chk("s3_inv_pulse_end", int'(cedulaINV), 0);
        note(4'd5);
        note(4'd2);
        chk("s3_soma7", int'(soma), 7);
        note(4'd5);
        chk("s3_over", int'(valoramais), 1);
        chk("s3_over_dev", int'(devolve), 1);
        chk("s3_over_soma", int'(soma), 7);
        @(negedge clk);
        chk("s3_over_held", int'(valoramais), 1);
        chk("s3_dev_pulse_end", int'(devolve), 0);
        step(0, 0, 1, 1, 4'd2);
        chk("s3_cancel_troco", int'(sel), 7);
        chk("s3_cancel_soma", int'(soma), 7);
        chk("s3_cancel_dev", int'(devolve), 1);
        chk("s3_over_clear", int'(valoramais), 0);
        wait_sel(3'b000, 50);

        // Com leite with 5+5 reaches the 10 cap, change 4.
        start_drink(2'b01);
        note(4'd5);
        note(4'd5);
        chk("s4_soma10", int'(soma), 10);
        @(negedge clk);
        chk("s4_bomba", int'(sel), 3);
        wait_sel(3'b111, 200);
        chk("s4_troco", int'(soma), 4);
        wait_sel(3'b000, 50);

        // Missing cup and capsule.
        copo_ok = 0; capsula_ok = 0;
        start_drink(2'b10);
        chk("s5_erro", int'(sel), 6);
        chk("s5_sensor", int'(sensor), 6);
        agua_ok = 0;
        @(negedge clk);
        chk("s5_sensor_live", int'(sensor), 7);
        agua_ok = 1; copo_ok = 1; capsula_ok = 1;
        @(negedge clk);
        step(0, 1, 0, 0, 0);
        chk("s5_back_sel", int'(sel), 1);
        chk("s5_sensor_clr", int'(sensor), 0);
        step(0, 0, 1, 0, 0);
        chk("s5_cancel_idle", int'(sel), 0);
        start_drink(2'b00);
        step(0, 0, 1, 0, 0);
        chk("s5_cancel_pag_zero", int'(sel), 0);

        // Reset in the middle of heating.
        start_drink(2'b00);
        note(4'd2);
        note(4'd2);
        wait_sel(3'b100, 100);
        chk("s6_aquec_on", int'(aquecedor), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_sel", int'(sel), 0);
        chk("s6_rst_all", int'({soma, sensor, cedulaINV, valoramais, bomba, aquecedor, entrega, devolve}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef CAFETEIRA_TIMEOUT_EN
        // Payment abandoned with 5 in credit.
        start_drink(2'b11);
        note(4'd5);
        wait_sel(3'b111, 1100);
        chk("s7_tmo_soma", int'(soma), 5);
        wait_sel(3'b000, 50);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
